threadgroup_seq: RTL and testbench
==================================

# threadgroup_seq

Sequencer for one 4-FEDP threadgroup: runs a K-loop of int8 dot-product steps for a 2×2 output tile, keeps the four 16-bit accumulators, and presents the finished tile downstream. Accepts operand words from a valid/ready stream and drives the threadgroup's weight/activation groups and partial sums. Reads back the threadgroup results, then hands out the tile on a valid/ready output port. Sits between the operand buffers and the threadgroup datapath in the TensorCore.

## Interface
- FEDP_LAT, 2: cycles from threadgroup inputs changing to results valid (0 = combinational datapath).
- KW, 8: width of k_steps.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a tile; sampled only in IDLE.
- clear  in  1  synchronous abort to IDLE; dominates all other inputs.
- k_steps  in  KW  number of 4-element K chunks; latched on start.
- busy  out  1  high in every state except IDLE.
- op_valid / op_ready  in / out  1  operand handshake.
- op_w0, op_w1, op_a0, op_a1  in  32 each  weight_group0/1 and activation_group0/1 words; byte i = element i, signed.
- tg_w0, tg_w1, tg_a0, tg_a1  out  32 each  registered drive to the threadgroup.
- tg_ps0..tg_ps3  out  16 each  partial sums to FEDP 0..3.
- tg_res0..tg_res3  in  16 each  threadgroup results.
- out_valid / out_ready  out / in  1  tile handshake.
- out_res0..out_res3  out  16 each  final accumulators; FEDP n pairs w(n/2) with a(n%2).

## Operation
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: on start, latch k_steps, zero acc0..3 and the step counter. If k_steps==0, go to OUTPUT; otherwise go to ISSUE.
- ISSUE: op_ready=1.
  - On op_valid&&op_ready, load the tg_* operand registers and go to WAIT.
  - op_ready is 0 in every other state.
- WAIT: hold tg_* stable. A down-counter loaded with FEDP_LAT runs; on the final WAIT cycle capture acc_n <= tg_res_n and increment the step counter.
  - If step == k_steps, go to OUTPUT; otherwise go to ISSUE.
- OUTPUT: out_valid=1 and out_res_n=acc_n, both stable until out_ready. On out_valid&&out_ready go to IDLE.
- tg_ps_n = acc_n at all times. Step 1 therefore sees 0.
- Arithmetic: none in this block. Accumulation is done by the FEDPs; the captured result wraps mod 2^16 with no saturation.
- start while busy is ignored.
- clear in any state: go to IDLE, drop out_valid, zero acc and the operand registers. No operand is accepted in a cycle where clear=1.
- Reset values: state IDLE, busy 0, op_ready 0, out_valid 0; tg_*, acc, out_res, counters all 0.

## Timing
- Operand accepted at edge T → tg_* change in cycle T+1 → results valid in cycle T+1+FEDP_LAT, captured at the end of that cycle.
- WAIT lasts FEDP_LAT+1 cycles.
- Step period with no stalls = FEDP_LAT+2 cycles (ISSUE 1, WAIT FEDP_LAT+1).
- Tile latency from start with op_valid held high = 1 + k_steps·(FEDP_LAT+2) cycles to first out_valid.
- k_steps==0: out_valid 1 cycle after start, results 0.
- op_valid low in ISSUE stalls without limit, with no state change.
- out_ready low holds OUTPUT without limit.
- Reset asserted mid-WAIT: every output is at its reset value in that cycle, and a capture still pending is discarded.

## Structure
- Shared TensorCore package: state enum (IDLE/ISSUE/WAIT/OUTPUT), INT8_W=8, ACC_W=16, LANES=4.
- The threadgroup is instantiated by the parent, not inside this block.
- One sub-module is natural: tg_lat_cnt, the WAIT down-counter with load/zero/expire, parameterised by FEDP_LAT.

## Test plan
All cases use FEDP_LAT=2 and a behavioural threadgroup model.
- k_steps=1, w0=w1=0x01010101, a0=a1=0x02020202, op_valid high → out_valid at cycle 5 after start; all results 0x0008.
- k_steps=3, same operands, out_ready high → results 0x0018. A second start while busy is ignored. busy falls the cycle after the handshake.
- k_steps=1, w0=0xFFFFFFFF, a0=0x01010101, w1=a1=0 → out_res0=0xFFFC, out_res1..3=0x0000.
- k_steps=2, all bytes 0x7F → step 1 gives 0xFC04 (64516 wraps). Step 2 gives 0xF808; no saturation.
- Backpressure: op_valid toggled 1-of-3 cycles and out_ready held low 5 cycles → results identical to the no-stall run, with out_res stable throughout the hold.
- Reset, then abort:
  - rst low in the second WAIT cycle of step 2 → all outputs 0 the same cycle; a fresh k_steps=1 tile after reset yields correct values.
  - clear in ISSUE → next cycle IDLE with op_ready 0.

Source files
------------

// File: rtl/threadgroup_seq_pkg.sv
// Shared TensorCore definitions for the threadgroup sequencer.
//   tg_state_t : sequencer states (IDLE / ISSUE / WAIT / OUTPUT)
//   INT8_W     : operand element width
//   ACC_W      : accumulator / partial-sum width
//   LANES      : FEDPs per threadgroup, also elements per operand word
package threadgroup_seq_pkg;

  localparam int unsigned INT8_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = INT8_W * LANES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } tg_state_t;

endpackage

// File: rtl/threadgroup_seq_lat_cnt.sv
// Down-counter that times the WAIT phase of one dot-product step.
//   clk, rst : clock, asynchronous active-low reset
//   zero     : synchronous clear to 0 (dominates load)
//   load     : load FEDP_LAT (operand accepted)
//   dec      : count down while non-zero
//   expire   : count is 0; with dec held, high on the final WAIT cycle
module tg_lat_cnt #(
  parameter int unsigned FEDP_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic zero,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned CW = (FEDP_LAT > 0) ? $clog2(FEDP_LAT + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(FEDP_LAT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/threadgroup_seq.sv
// Sequencer for one 4-FEDP threadgroup computing a 2x2 int8 output tile.
// Runs k_steps dot-product steps: takes an operand set from the op_* stream,
// drives it to the threadgroup, waits FEDP_LAT+1 cycles, captures the four
// results into the accumulators (fed back as partial sums), then presents
// the finished tile on the out_* handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   start, k_steps      : begin a tile of k_steps steps (IDLE only)
//   clear               : synchronous abort to IDLE, zeroes acc/operands
//   busy                : not IDLE
//   op_valid/op_ready   : operand handshake, op_w0/op_w1/op_a0/op_a1 words
//   tg_w*/tg_a*         : registered operand drive to the threadgroup
//   tg_ps0..3           : partial sums (= accumulators)
//   tg_res0..3          : threadgroup results
//   out_valid/out_ready : tile handshake, out_res0..3 final accumulators
module threadgroup_seq
  import threadgroup_seq_pkg::*;
#(
  parameter int unsigned FEDP_LAT = 2,
  parameter int unsigned KW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [KW-1:0]     k_steps,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [WORD_W-1:0] op_w0,
  input  logic [WORD_W-1:0] op_w1,
  input  logic [WORD_W-1:0] op_a0,
  input  logic [WORD_W-1:0] op_a1,
  output logic [WORD_W-1:0] tg_w0,
  output logic [WORD_W-1:0] tg_w1,
  output logic [WORD_W-1:0] tg_a0,
  output logic [WORD_W-1:0] tg_a1,
  output logic [ACC_W-1:0]  tg_ps0,
  output logic [ACC_W-1:0]  tg_ps1,
  output logic [ACC_W-1:0]  tg_ps2,
  output logic [ACC_W-1:0]  tg_ps3,
  input  logic [ACC_W-1:0]  tg_res0,
  input  logic [ACC_W-1:0]  tg_res1,
  input  logic [ACC_W-1:0]  tg_res2,
  input  logic [ACC_W-1:0]  tg_res3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_res0,
  output logic [ACC_W-1:0]  out_res1,
  output logic [ACC_W-1:0]  out_res2,
  output logic [ACC_W-1:0]  out_res3
);

  tg_state_t state, state_nx;

  logic [LANES-1:0][ACC_W-1:0] acc;
  logic [LANES-1:0][ACC_W-1:0] res_in;
  logic [KW-1:0]               k_lat;
  logic [KW-1:0]               step;
  logic [KW-1:0]               step_inc;

  logic start_tile;
  logic accept;
  logic capture;
  logic in_wait;
  logic cnt_expire;

  assign res_in   = {tg_res3, tg_res2, tg_res1, tg_res0};
  assign step_inc = step + KW'(1);

  tg_lat_cnt #(
    .FEDP_LAT(FEDP_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .zero   (clear),
    .load   (accept),
    .dec    (in_wait),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    start_tile = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    busy       = (state != IDLE);
    in_wait    = (state == WAIT);
    out_valid  = (state == OUTPUT);
    // Ready is masked by clear so an aborting cycle never looks like a
    // completed transfer to the operand source.
    op_ready   = (state == ISSUE) && !clear;

    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            start_tile = 1'b1;
            state_nx   = (k_steps == '0) ? OUTPUT : ISSUE;
          end
        end
        ISSUE: begin
          if (op_valid) begin
            accept   = 1'b1;
            state_nx = WAIT;
          end
        end
        WAIT: begin
          if (cnt_expire) begin
            capture  = 1'b1;
            state_nx = (step_inc == k_lat) ? OUTPUT : ISSUE;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tg_w0 <= '0;
      tg_w1 <= '0;
      tg_a0 <= '0;
      tg_a1 <= '0;
      acc   <= '0;
      k_lat <= '0;
      step  <= '0;
    end else if (clear) begin
      tg_w0 <= '0;
      tg_w1 <= '0;
      tg_a0 <= '0;
      tg_a1 <= '0;
      acc   <= '0;
      k_lat <= '0;
      step  <= '0;
    end else begin
      if (start_tile) begin
        k_lat <= k_steps;
        step  <= '0;
        acc   <= '0;
      end
      if (accept) begin
        tg_w0 <= op_w0;
        tg_w1 <= op_w1;
        tg_a0 <= op_a0;
        tg_a1 <= op_a1;
      end
      if (capture) begin
        acc  <= res_in;
        step <= step_inc;
      end
    end
  end

  assign tg_ps0   = acc[0];
  assign tg_ps1   = acc[1];
  assign tg_ps2   = acc[2];
  assign tg_ps3   = acc[3];
  assign out_res0 = acc[0];
  assign out_res1 = acc[1];
  assign out_res2 = acc[2];
  assign out_res3 = acc[3];

endmodule

// File: tb/tb_threadgroup_seq.sv
`timescale 1ns/1ps
module tb_threadgroup_seq;

  localparam int FEDP_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, start, clear, op_valid, out_ready;
  logic [7:0]  k_steps;
  logic        busy, op_ready, out_valid;
  logic [31:0] op_w0, op_w1, op_a0, op_a1;
  logic [31:0] tg_w0, tg_w1, tg_a0, tg_a1;
  logic [15:0] tg_ps0, tg_ps1, tg_ps2, tg_ps3;
  logic [15:0] tg_res0, tg_res1, tg_res2, tg_res3;
  logic [15:0] out_res0, out_res1, out_res2, out_res3;

  int tests  = 0;
  int failed = 0;

  threadgroup_seq #(.FEDP_LAT(FEDP_LAT), .KW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .k_steps(k_steps),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
    .op_w0(op_w0), .op_w1(op_w1), .op_a0(op_a0), .op_a1(op_a1),
    .tg_w0(tg_w0), .tg_w1(tg_w1), .tg_a0(tg_a0), .tg_a1(tg_a1),
    .tg_ps0(tg_ps0), .tg_ps1(tg_ps1), .tg_ps2(tg_ps2), .tg_ps3(tg_ps3),
    .tg_res0(tg_res0), .tg_res1(tg_res1), .tg_res2(tg_res2), .tg_res3(tg_res3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res0(out_res0), .out_res1(out_res1), .out_res2(out_res2), .out_res3(out_res3)
  );

  always #5 clk = ~clk;

  // Signed int8 4-element dot product, wrapped to 16 bits.
  function automatic logic [15:0] dot(input logic [31:0] w, input logic [31:0] a);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(w[8*i +: 8])) * int'($signed(a[8*i +: 8]));
    return s[15:0];
  endfunction

  // Behavioural threadgroup: result = ps + dot, visible FEDP_LAT cycles later.
  logic [3:0][15:0] tg_now;
  logic [3:0][15:0] pipe [FEDP_LAT];
  always_comb begin
    tg_now[0] = tg_ps0 + dot(tg_w0, tg_a0);
    tg_now[1] = tg_ps1 + dot(tg_w0, tg_a1);
    tg_now[2] = tg_ps2 + dot(tg_w1, tg_a0);
    tg_now[3] = tg_ps3 + dot(tg_w1, tg_a1);
  end
  always_ff @(posedge clk) begin
    pipe[0] <= tg_now;
    for (int i = 1; i < FEDP_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {tg_res3, tg_res2, tg_res1, tg_res0} = pipe[FEDP_LAT-1];

  typedef struct {
    logic [31:0] w0, w1, a0, a1;
  } ops_t;
  ops_t opq[$];
  ops_t saved[$];

  typedef struct {
    int               k;
    bit               poke;
    logic [31:0]      w0, w1, a0, a1;
    logic [3:0][15:0] e;
    int               lat;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [3:0][15:0] out_bus();
    return {out_res3, out_res2, out_res1, out_res0};
  endfunction

  // Tile result from the definition: each FEDP accumulates its w/a pairing.
  function automatic logic [3:0][15:0] model_tile(input ops_t q[$]);
    logic [3:0][15:0] r;
    r = '0;
    foreach (q[s]) begin
      r[0] += dot(q[s].w0, q[s].a0);
      r[1] += dot(q[s].w0, q[s].a1);
      r[2] += dot(q[s].w1, q[s].a0);
      r[3] += dot(q[s].w1, q[s].a1);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_op_ready"}, op_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_tg_w"}, {tg_w1, tg_w0}, 0);
    check({tag, "_tg_a"}, {tg_a1, tg_a0}, 0);
    check({tag, "_tg_ps"}, {tg_ps3, tg_ps2, tg_ps1, tg_ps0}, 0);
    check({tag, "_out_res"}, out_bus(), 0);
  endtask

  task automatic set_ops(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] a0, input logic [31:0] a1);
    op_w0 = w0; op_w1 = w1; op_a0 = a0; op_a1 = a1;
  endtask

  task automatic fill_const(input int k, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] a0, input logic [31:0] a1);
    ops_t o;
    o.w0 = w0; o.w1 = w1; o.a0 = a0; o.a1 = a1;
    opq.delete();
    for (int s = 0; s < k; s++) opq.push_back(o);
  endtask

  task automatic fill_rand(input int k);
    ops_t o;
    opq.delete();
    for (int s = 0; s < k; s++) begin
      o.w0 = $urandom; o.w1 = $urandom; o.a0 = $urandom; o.a1 = $urandom;
      opq.push_back(o);
    end
  endtask

  // Runs one tile from opq. lat = cycles from the start edge to first out_valid.
  task automatic run_tile(input int k, input bit stall, input int hold, input bit poke,
                          output int lat, output logic [3:0][15:0] r);
    int held;
    bit pop;
    logic [3:0][15:0] snap;
    lat = -1; r = '0; held = 0; snap = '0;
    start = 1; k_steps = 8'(k); op_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    start = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      pop = 0;
      if (poke) begin
        start = (cyc == 2);
        if (cyc == 2) k_steps = 8'd5;
      end
      if (out_valid) begin
        op_valid = 0;
        if (lat < 0) begin
          lat = cyc;
          snap = out_bus();
        end else begin
          check("hold_stable", out_bus(), snap);
        end
        if (held < hold) begin
          held++;
          out_ready = 0;
        end else begin
          out_ready = 1;
          r = out_bus();
          @(posedge clk); #1;
          out_ready = 0; start = 0;
          check("busy_after_hs", busy, 0);
          check("valid_after_hs", out_valid, 0);
          check("ops_consumed", opq.size(), 0);
          return;
        end
      end else if (opq.size() > 0) begin
        set_ops(opq[0].w0, opq[0].w1, opq[0].a0, opq[0].a1);
        op_valid = stall ? (cyc % 3 == 0) : 1'b1;
        pop = op_valid && op_ready;
      end else begin
        op_valid = 0;
      end
      @(posedge clk);
      if (pop) void'(opq.pop_front());
      #1;
    end
    check("tile_timeout", 1, 0);
    start = 0; op_valid = 0; clear = 1;
    @(posedge clk); #1;
    clear = 0;
    opq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, k, hold;
    bit stall;
    logic [3:0][15:0] r, exp_r;

    rst = 0; start = 0; clear = 0; op_valid = 0; out_ready = 0; k_steps = '0;
    set_ops('0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1;
    @(posedge clk); #1;

    vecs[0] = '{1, 1'b0, 32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202,
                64'h0008_0008_0008_0008, 5};
    vecs[1] = '{3, 1'b1, 32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202,
                64'h0018_0018_0018_0018, 13};
    vecs[2] = '{1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h01010101, 32'h00000000,
                64'h0000_0000_0000_FFFC, 5};
    vecs[3] = '{2, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F,
                64'hF808_F808_F808_F808, 9};
    vecs[4] = '{0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0,
                64'h0000_0000_0000_0000, 1};

    foreach (vecs[i]) begin
      fill_const(vecs[i].k, vecs[i].w0, vecs[i].w1, vecs[i].a0, vecs[i].a1);
      run_tile(vecs[i].k, 1'b0, 0, vecs[i].poke, lat, r);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_res", i), r, vecs[i].e);
    end

    // Backpressure: same operands with and without stalls give the same tile.
    fill_rand(3);
    saved = opq;
    exp_r = model_tile(opq);
    run_tile(3, 1'b0, 0, 1'b0, lat, r);
    check("bp_nostall_lat", lat, 1 + 3 * (FEDP_LAT + 2));
    check("bp_nostall_res", r, exp_r);
    opq = saved;
    run_tile(3, 1'b1, 5, 1'b0, lat, r);
    check("bp_stall_res", r, exp_r);

    for (int t = 0; t < 12; t++) begin
      k = $urandom_range(0, 4);
      stall = 1'($urandom % 2);
      hold = $urandom_range(0, 3);
      fill_rand(k);
      exp_r = model_tile(opq);
      run_tile(k, stall, hold, 1'b0, lat, r);
      check($sformatf("rand%0d_res", t), r, exp_r);
      if (!stall) check($sformatf("rand%0d_lat", t), lat, 1 + k * (FEDP_LAT + 2));
    end

    // Reset asserted in the second WAIT cycle of step 2.
    set_ops(32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202);
    op_valid = 1; start = 1; k_steps = 8'd2;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    check("midwait_ps_step1", tg_ps0, 16'h0008);
    check("midwait_busy", busy, 1);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check_all_zero("midwait_rst");
    @(posedge clk); #1;
    rst = 1; op_valid = 0;
    fill_const(1, 32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202);
    run_tile(1, 1'b0, 0, 1'b0, lat, r);
    check("post_rst_res", r, 64'h0008_0008_0008_0008);
    check("post_rst_lat", lat, 5);

    // Clear in ISSUE: nothing accepted, back to IDLE.
    set_ops(32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202);
    op_valid = 1; start = 1; k_steps = 8'd2;
    @(posedge clk); #1;
    start = 0;
    check("clr_issue_ready_pre", busy, 1);
    clear = 1;
    #1;
    check("clr_issue_ready_masked", op_ready, 0);
    @(posedge clk); #1;
    clear = 0; op_valid = 0;
    check("clr_issue_busy", busy, 0);
    check("clr_issue_ready", op_ready, 0);
    check("clr_issue_tg_w0", tg_w0, 0);

    // Clear in OUTPUT: drops out_valid and zeroes the tile.
    op_valid = 1; start = 1; k_steps = 8'd1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    op_valid = 0;
    check("clr_out_reached", out_valid, 1);
    check("clr_out_res0", out_res0, 16'h0008);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    check("clr_out_valid", out_valid, 0);
    check("clr_out_busy", busy, 0);
    check("clr_out_res", out_bus(), 0);
    check("clr_out_tg_w0", tg_w0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
